// File: rtl/phv_rx_pkg.sv
// -----------------------------------------------------------------------------
// phv_rx_pkg
// Shared definitions for the PHV receive FIFO in front of the deparser.
//   PHV_LEN_DEFAULT : default PHV width (48*8 + 32*8 + 16*8 + 256 bits)
//   PHV_PORT_OFF    : default LSB of the output-port bitmap inside a PHV
//   PORT_W          : width of the output-port bitmap
//   CNT_W           : width of the drop statistics counters
//   in_disp_e       : what happens to the PHV offered on a given cycle
//   sat_inc()       : saturating increment for the statistics counters
// -----------------------------------------------------------------------------
package phv_rx_pkg;

  localparam int PHV_LEN_DEFAULT = 1024;
  localparam int PHV_PORT_OFF    = 141;
  localparam int PORT_W          = 4;
  localparam int CNT_W           = 32;

  // Fate of the PHV presented on phv_in this cycle
  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_PUSH = 2'd1,
    DISP_NULL = 2'd2,
    DISP_OVF  = 2'd3
  } in_disp_e;

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == {CNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/phv_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// phv_rx_fifo_mem
// DEPTH x WIDTH storage for the PHV FIFO. Synchronous write, asynchronous read
// so the head entry is visible combinationally (first-word-fall-through).
// Contents are deliberately not reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data (combinational)
// -----------------------------------------------------------------------------
module phv_rx_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/phv_rx_fifo.sv
// -----------------------------------------------------------------------------
// phv_rx_fifo
// Receive queue between the last match-action stage and the deparser. The
// pipeline cannot stall, so phv_fifo_ready is an early (almost-full) warning
// leaving AF_MARGIN entries for PHVs already in flight. PHVs with an empty
// output-port bitmap are discarded on entry; PHVs that find the queue full are
// discarded too. Both kinds of drop are counted.
//   axis_clk       : clock
//   areset         : asynchronous active-high reset
//   phv_in         : PHV from the final pipeline stage
//   phv_in_valid   : phv_in carries a PHV this cycle
//   phv_fifo_ready : registered almost-full backpressure (1 = room)
//   phv_out        : head-of-queue PHV (0 when empty)
//   phv_out_valid  : queue not empty
//   phv_out_ready  : deparser takes the head entry
//   occupancy      : current entry count
//   drop_ovf_cnt   : saturating count of PHVs lost to a full queue
//   drop_null_cnt  : saturating count of PHVs with a zero port bitmap
//   high_water     : maximum occupancy since reset
// -----------------------------------------------------------------------------
module phv_rx_fifo
  import phv_rx_pkg::*;
#(
  parameter int PHV_LEN   = PHV_LEN_DEFAULT,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  parameter int PORT_OFF  = PHV_PORT_OFF
) (
  input  logic                       axis_clk,
  input  logic                       areset,
  input  logic [PHV_LEN-1:0]         phv_in,
  input  logic                       phv_in_valid,
  output logic                       phv_fifo_ready,
  output logic [PHV_LEN-1:0]         phv_out,
  output logic                       phv_out_valid,
  input  logic                       phv_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           drop_ovf_cnt,
  output logic [CNT_W-1:0]           drop_null_cnt,
  output logic [$clog2(DEPTH+1)-1:0] high_water
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_next_s;
  logic [CW-1:0]      high_water_r;
  logic               valid_r;
  logic               ready_r;
  logic               armed_r;
  logic [CNT_W-1:0]   drop_ovf_r;
  logic [CNT_W-1:0]   drop_null_r;
  logic [PORT_W-1:0]  bitmap_s;
  logic               pop_s;
  logic               push_s;
  in_disp_e           disp_s;
  logic [PHV_LEN-1:0] rd_data_s;

  assign bitmap_s = phv_in[PORT_OFF +: PORT_W];
  assign pop_s    = valid_r & phv_out_ready;
  assign push_s   = (disp_s == DISP_PUSH);

  // Classify the offered PHV; nothing is accepted on the first edge after reset
  always_comb begin
    disp_s = DISP_IDLE;
    if (!phv_in_valid || !armed_r) begin
      disp_s = DISP_IDLE;
    end else if (bitmap_s == {PORT_W{1'b0}}) begin
      disp_s = DISP_NULL;
    end else if ((count_r < FULL_LVL) || pop_s) begin
      disp_s = DISP_PUSH;
    end else begin
      disp_s = DISP_OVF;
    end
  end

  // Next entry count from the push/pop pair
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and the flags derived from the next count
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      valid_r      <= 1'b0;
      ready_r      <= 1'b1;
      high_water_r <= {CW{1'b0}};
      armed_r      <= 1'b0;
    end else begin
      armed_r <= 1'b1;
      // power-of-two depth lets the pointers wrap naturally
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CW{1'b0}});
      ready_r <= (count_next_s < AF_LVL);
      if (count_next_s > high_water_r) begin
        high_water_r <= count_next_s;
      end
    end
  end

  // Drop statistics
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      drop_ovf_r  <= {CNT_W{1'b0}};
      drop_null_r <= {CNT_W{1'b0}};
    end else begin
      case (disp_s)
        DISP_NULL: drop_null_r <= sat_inc(drop_null_r);
        DISP_OVF:  drop_ovf_r  <= sat_inc(drop_ovf_r);
        default: begin
          drop_ovf_r  <= drop_ovf_r;
          drop_null_r <= drop_null_r;
        end
      endcase
    end
  end

  phv_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PHV_LEN),
    .AW    (AW)
  ) u_mem (
    .clk     (axis_clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (phv_in),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Storage is not reset, so mask the head entry while the queue is empty
  always_comb begin
    phv_out = {PHV_LEN{1'b0}};
    if (valid_r) begin
      phv_out = rd_data_s;
    end else begin
      phv_out = {PHV_LEN{1'b0}};
    end
  end

  assign phv_out_valid  = valid_r;
  assign phv_fifo_ready = ready_r;
  assign occupancy      = count_r;
  assign high_water     = high_water_r;
  assign drop_ovf_cnt   = drop_ovf_r;
  assign drop_null_cnt  = drop_null_r;

endmodule

// File: doc/phv_rx_fifo.md
PHV_RX_FIFO -- requirements
Module: phv_rx_fifo

Interface
REQ-001 Parameter PHV_LEN, default 1024, PHV width in bits (48*8+32*8+16*8+256).
REQ-002 Parameter DEPTH, default 16, entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter AF_MARGIN, default 4, free entries reserved for in-flight PHVs after ready deasserts; SHALL be less than DEPTH.
REQ-004 Parameter PORT_OFF, default 141, LSB of the 4-bit output-port bitmap inside the PHV.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 axis_clk  in  1  clock, all logic rising-edge.
REQ-007 areset  in  1  asynchronous active-high reset.
REQ-008 phv_in  in  PHV_LEN  PHV from the final pipeline stage.
REQ-009 phv_in_valid  in  1  one PHV per asserted cycle; upstream has no stall path.
REQ-010 phv_fifo_ready  out  1  registered almost-full backpressure to the pipeline.
REQ-011 phv_out  out  PHV_LEN  head-of-queue PHV to the deparser.
REQ-012 phv_out_valid  out  1  head entry present.
REQ-013 phv_out_ready  in  1  deparser accepts the head entry.
REQ-014 occupancy  out  $clog2(DEPTH+1)  current entry count.
REQ-015 drop_ovf_cnt  out  32  saturating count of PHVs dropped because the queue was full.
REQ-016 drop_null_cnt  out  32  saturating count of PHVs dropped because the port bitmap was zero.
REQ-017 high_water  out  $clog2(DEPTH+1)  maximum occupancy since reset.

Function
REQ-018 Push = phv_in_valid & (phv_in[PORT_OFF+:4] != 0) & (count < DEPTH | pop); pop = phv_out_valid & phv_out_ready.
REQ-019 phv_in_valid with a zero port bitmap SHALL be discarded and increment drop_null_cnt, whatever the occupancy.
REQ-020 phv_in_valid with a nonzero bitmap while count == DEPTH and no pop SHALL be discarded and increment drop_ovf_cnt.
REQ-021 Both drop counters SHALL saturate at 0xFFFFFFFF.
REQ-022 Output is first-word-fall-through: phv_out_valid = (count != 0); phv_out = entry at read pointer; phv_out SHALL be held stable while valid and not ready.
REQ-023 No bypass: a PHV pushed into an empty queue SHALL appear on phv_out exactly 1 cycle later.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, including at count == DEPTH and at count == 1.
REQ-025 Read and write pointers are log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-026 phv_fifo_ready SHALL be registered, equal to (count_next < DEPTH - AF_MARGIN).
REQ-027 high_water SHALL update to count_next whenever count_next exceeds it.
REQ-028 No state machine; state is the pointers, count, and counters only.

Reset
REQ-029 On areset: pointers, count, occupancy, high_water, and both drop counters SHALL be 0.
REQ-030 On areset: phv_out_valid SHALL be 0, phv_fifo_ready SHALL be 1, and phv_out SHALL be 0.
REQ-031 Storage contents need not be reset.
REQ-032 Reset mid-traffic SHALL discard all queued PHVs.
REQ-033 Any phv_in_valid in the deassertion cycle SHALL be ignored.

Structure
REQ-034 Shared package phv_rx_pkg SHALL hold the PHV_LEN default, PORT_OFF, the port-bitmap width (4), and the counter width (32).
REQ-035 Storage SHALL be sub-module phv_rx_fifo_mem: synchronous write, asynchronous read, DEPTH x PHV_LEN.

Verification
REQ-036 Push 1 PHV (bitmap 4'b0001) into an empty queue with phv_out_ready=1 -> phv_out_valid rises exactly 1 cycle later, occupancy returns to 0.
REQ-037 phv_out_ready=0, push 12 PHVs back-to-back -> phv_fifo_ready falls on the cycle after the 12th push; occupancy=12, high_water=12.
REQ-038 phv_out_ready=0, push 20 PHVs -> occupancy=16, drop_ovf_cnt=4; on drain, output order matches the first 16 inputs.
REQ-039 Full queue, simultaneous push and pop for 40 cycles -> occupancy stays 16, no drops, all pointers wrap, data order preserved.
REQ-040 Push 3 PHVs with bitmap 4'b0000 interleaved with 2 valid PHVs -> drop_null_cnt=3, exactly 2 entries are output.
REQ-041 Assert areset with 8 entries queued -> phv_out_valid=0, occupancy=0, phv_fifo_ready=1, counters=0 immediately.
